// File: rtl/alu_issue_stage.sv
// alu_issue_stage: register file, pending scoreboard and one-deep
// issue register feeding operands to the 8-bit ALU.
module alu_issue_stage #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          InValid,
  output logic          InReady,
  input  logic [1:0]    InOp,
  input  logic [AW-1:0] InRegA,
  input  logic [AW-1:0] InRegB,
  input  logic [AW-1:0] InRegD,
  input  logic          InImmSel,
  input  logic [DW-1:0] InImm,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [1:0]    ALUOp,
  output logic [DW-1:0] ALUSrcA,
  output logic [DW-1:0] ALUSrcB,
  output logic [AW-1:0] OutRegD,
  input  logic          WbEn,
  input  logic [AW-1:0] WbReg,
  input  logic [DW-1:0] WbData
);

  logic [DW-1:0]   rf [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] wbHit;
  logic [NREG-1:0] setHit;
  logic [NREG-1:0] effPend;
  logic [DW-1:0]   opA;
  logic [DW-1:0]   opB;
  logic            hazard;
  logic            space;
  logic            accept;

  always_comb begin
    wbHit = '0;
    if (WbEn) wbHit[WbReg] = 1'b1;
  end

  always_comb begin
    setHit = '0;
    if (accept) setHit[InRegD] = 1'b1;
  end

  // A same-cycle writeback both satisfies the hazard and supplies data.
  assign effPend = pending & ~wbHit;

  assign opA = wbHit[InRegA] ? WbData : rf[InRegA];
  assign opB = InImmSel       ? InImm
             : wbHit[InRegB] ? WbData
             :                 rf[InRegB];

  assign hazard = effPend[InRegA]
                | (effPend[InRegB] & ~InImmSel)
                | effPend[InRegD];

  assign space   = ~OutValid | OutReady;
  assign InReady = space & ~hazard;
  assign accept  = InValid & InReady;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (WbEn) begin
      rf[WbReg] <= WbData;
    end
  end

  // Set from a new issue overrides a clear from writeback.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) pending <= '0;
    else          pending <= (pending & ~wbHit) | setHit;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      OutValid <= 1'b0;
      ALUOp    <= '0;
      ALUSrcA  <= '0;
      ALUSrcB  <= '0;
      OutRegD  <= '0;
    end else if (accept) begin
      OutValid <= 1'b1;
      ALUOp    <= InOp;
      ALUSrcA  <= opA;
      ALUSrcB  <= opB;
      OutRegD  <= InRegD;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule
